mma_pe_acc: RTL and testbench

- Parametrised, pipelined processing element for the systolic matrix-multiply array; successor of the basic 8-bit MAC PE.
- Forwards A (east) and B (south) operands with valid/first tags, and accumulates A*B in an output-stationary accumulator.
- Adds configurable widths, signed/unsigned mode, saturating accumulation with a sticky overflow flag, tile restart without reset, and a shift-chain drain path.
- Drain path: one row of PEs can unload results into the array's edge collector while the next tile accumulates.

---
 rtl/mma_pkg.sv | 58 +++++
 rtl/mma_mul_stage.sv | 57 +++++
 rtl/mma_pe_acc.sv | 91 +++++++++
 tb/tb_mma_pe_acc.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mma_pkg.sv
// Shared definitions for the matrix-multiply PE family: default widths, accumulator
// limits and the saturating/wrapping accumulate helper.
package mma_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 32;
    // Widest accumulator sat_add supports; callers pass their own ACC_W.
    localparam int unsigned MAX_ACC_W  = 64;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX_SIGNED   = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN_SIGNED   = {1'b1, {(ACC_W_DEF-1){1'b0}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MAX_UNSIGNED = {ACC_W_DEF{1'b1}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN_UNSIGNED = '0;

    function automatic logic [MAX_ACC_W-1:0] acc_max(input int unsigned acc_w,
                                                     input bit is_signed);
        return {MAX_ACC_W{1'b1}} >> (MAX_ACC_W - acc_w + (is_signed ? 32'd1 : 32'd0));
    endfunction

    function automatic logic [MAX_ACC_W-1:0] acc_min(input int unsigned acc_w,
                                                     input bit is_signed);
        logic [MAX_ACC_W-1:0] one;
        one = {{(MAX_ACC_W-1){1'b0}}, 1'b1};
        return is_signed ? (one << (acc_w - 1)) : '0;
    endfunction

    function automatic logic bit_at(input logic [MAX_ACC_W:0] v, input int unsigned idx);
        logic [MAX_ACC_W:0] s;
        s = v >> idx;
        return s[0];
    endfunction

    // Returns {ovf, result}; only the low acc_w bits of base/prod/result are meaningful.
    function automatic logic [MAX_ACC_W:0] sat_add(input logic [MAX_ACC_W-1:0] base,
                                                   input logic [MAX_ACC_W-1:0] prod,
                                                   input int unsigned          acc_w,
                                                   input bit                   is_signed,
                                                   input bit                   saturate);
        logic [MAX_ACC_W:0]   hi_mask, base_x, prod_x, sum;
        logic [MAX_ACC_W-1:0] result;
        logic                 top, below, ovf;
        hi_mask = {(MAX_ACC_W+1){1'b1}} << acc_w;
        base_x  = {1'b0, base} & ~hi_mask;
        prod_x  = {1'b0, prod} & ~hi_mask;
        if (is_signed && bit_at(base_x, acc_w - 1)) base_x = base_x | hi_mask;
        if (is_signed && bit_at(prod_x, acc_w - 1)) prod_x = prod_x | hi_mask;
        sum    = base_x + prod_x;
        top    = bit_at(sum, acc_w);
        below  = bit_at(sum, acc_w - 1);
        ovf    = is_signed ? (top ^ below) : top;
        result = sum[MAX_ACC_W-1:0] & ~hi_mask[MAX_ACC_W-1:0];
        if (ovf && saturate) begin
            result = (is_signed && top) ? acc_min(acc_w, is_signed) : acc_max(acc_w, is_signed);
        end
        return {ovf, result};
    endfunction

endpackage

// File: rtl/mma_mul_stage.sv
// Stage 1 of the PE: registered operand forwarding plus a registered full-width product
// with its valid and tile-restart tags.
module mma_mul_stage
    import mma_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_first,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    output logic                out_valid,
    output logic                out_first,
    output logic [DATA_W-1:0]   out_a,
    output logic [DATA_W-1:0]   out_b,
    output logic [2*DATA_W-1:0] prod,
    output logic                prod_v,
    output logic                clr
);

    logic [2*DATA_W-1:0] ext_a, ext_b, prod_d;

    // Low 2*DATA_W bits of the extended product are exact in either mode.
    if (SIGNED) begin : g_sext
        assign ext_a = {{DATA_W{in_a[DATA_W-1]}}, in_a};
        assign ext_b = {{DATA_W{in_b[DATA_W-1]}}, in_b};
    end else begin : g_zext
        assign ext_a = {{DATA_W{1'b0}}, in_a};
        assign ext_b = {{DATA_W{1'b0}}, in_b};
    end

    assign prod_d = ext_a * ext_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            prod      <= '0;
            prod_v    <= 1'b0;
            clr       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_first <= in_first;
            out_a     <= in_a;
            out_b     <= in_b;
            prod      <= prod_d;
            prod_v    <= in_valid;
            clr       <= in_valid & in_first;
        end
    end

endmodule

// File: rtl/mma_pe_acc.sv
// Output-stationary systolic PE: forwards operands east/south, accumulates products with
// optional saturation and sticky overflow, and unloads results through a drain shift chain.
module mma_pe_acc
    import mma_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    output logic              out_first,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    input  logic              drain_load,
    input  logic              drain_shift,
    input  logic [ACC_W-1:0]  drain_in,
    output logic [ACC_W-1:0]  drain_out,
    output logic              ovf,
    output logic              busy
);

    logic [2*DATA_W-1:0]  prod;
    logic                 prod_v;
    logic                 clr;
    logic [MAX_ACC_W-1:0] prod_x;
    logic [MAX_ACC_W:0]   sat_sum;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 ovf_d;

    mma_mul_stage #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_a     (out_a),
        .out_b     (out_b),
        .prod      (prod),
        .prod_v    (prod_v),
        .clr       (clr)
    );

    if (SIGNED) begin : g_sext
        assign prod_x = MAX_ACC_W'($signed(prod));
    end else begin : g_zext
        assign prod_x = MAX_ACC_W'(prod);
    end

    assign busy = prod_v;

    always_comb begin
        sat_sum = sat_add(clr ? '0 : MAX_ACC_W'(acc_q), prod_x, ACC_W, SIGNED, SATURATE);
        acc_d   = acc_q;
        ovf_d   = ovf;
        if (prod_v) begin
            // A clamped accumulator stays pinned until the next tile restart.
            if (clr || !(SATURATE && ovf)) acc_d = ACC_W'(sat_sum[MAX_ACC_W-1:0]);
            ovf_d = (ovf && !clr) || sat_sum[MAX_ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            ovf       <= 1'b0;
            drain_out <= '0;
        end else begin
            acc_q <= acc_d;
            ovf   <= ovf_d;
            if (drain_load) begin
                drain_out <= acc_q;
            end else if (drain_shift) begin
                drain_out <= drain_in;
            end
        end
    end

endmodule

// File: tb/tb_mma_pe_acc.sv
// Scoreboard bench for mma_pe_acc: four PEs (two chained signed 32-bit, unsigned 16-bit
// saturating, unsigned 16-bit wrapping) driven by directed and random stimulus.
module tb_mma_pe_acc;

    localparam int NPE = 4;

    typedef struct {
        int         e;
        logic [7:0] a;
        logic [7:0] b;
        bit         fs;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        vld[NPE], fst[NPE], dl[NPE], ds[NPE];
    logic [7:0]  a[NPE], b[NPE];
    logic        ov[NPE], of[NPE], ovf[NPE], busy[NPE];
    logic [7:0]  oa[NPE], ob[NPE];
    logic [31:0] dout[NPE];

    int wd[NPE] = '{32, 32, 16, 16};
    bit sg[NPE] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit st[NPE] = '{1'b1, 1'b1, 1'b1, 1'b0};

    for (genvar g = 0; g < NPE; g++) begin : g_pe
        localparam int unsigned AW = (g < 2) ? 32 : 16;
        logic [AW-1:0] din, dq_w;
        if (g == 1) begin : g_chain
            assign din = AW'(dout[0]);
        end else begin : g_head
            assign din = '0;
        end
        mma_pe_acc #(
            .DATA_W   (8),
            .ACC_W    (AW),
            .SIGNED   (g < 2),
            .SATURATE (g != 3)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .in_valid    (vld[g]),
            .in_first    (fst[g]),
            .in_a        (a[g]),
            .in_b        (b[g]),
            .out_valid   (ov[g]),
            .out_first   (of[g]),
            .out_a       (oa[g]),
            .out_b       (ob[g]),
            .drain_load  (dl[g]),
            .drain_shift (ds[g]),
            .drain_in    (din),
            .drain_out   (dq_w),
            .ovf         (ovf[g]),
            .busy        (busy[g])
        );
        assign dout[g] = 32'(dq_w);
    end

    pair_t       hist[NPE][$];
    logic [16:0] fq[NPE][$];
    logic [32:0] dq[NPE][$];
    logic [31:0] dmodel[NPE];
    bit          dev[NPE], bexp[NPE];
    bit          mon_en = 1'b0;
    int          ec = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Accumulator value after all pairs sampled at edges <= upto, from plain arithmetic.
    function automatic void model(input int i, input int upto, output longint acc,
                                  output bit ov_o);
        longint prod, sum, hi, lo;
        acc  = 0;
        ov_o = 1'b0;
        hi   = sg[i] ? (64'sd1 <<< (wd[i] - 1)) - 1 : (64'sd1 <<< wd[i]) - 1;
        lo   = sg[i] ? -(64'sd1 <<< (wd[i] - 1)) : 0;
        for (int k = 0; k < hist[i].size(); k++) begin
            if (hist[i][k].e > upto) break;
            if (hist[i][k].fs) begin
                acc  = 0;
                ov_o = 1'b0;
            end
            if (sg[i]) prod = longint'($signed(hist[i][k].a)) * longint'($signed(hist[i][k].b));
            else       prod = longint'(hist[i][k].a) * longint'(hist[i][k].b);
            if (st[i] && ov_o) continue;
            sum = acc + prod;
            if (sum > hi || sum < lo) begin
                ov_o = 1'b1;
                if (st[i]) begin
                    acc = (sum > hi) ? hi : lo;
                end else begin
                    acc = sum & ((64'sd1 <<< wd[i]) - 1);
                    if (acc > hi) acc = acc - (64'sd1 <<< wd[i]);
                end
            end else begin
                acc = sum;
            end
        end
    endfunction

    // Records expectations for the coming edge, then advances one clock.
    task automatic cyc();
        int          e;
        longint      acc_m, m;
        bit          ovf_m, unused_ovf;
        logic [31:0] nd[NPE];
        e = ec + 1;
        for (int i = 0; i < NPE; i++) begin
            nd[i] = dmodel[i];
            if (vld[i] && !reset) begin
                hist[i].push_back('{e, a[i], b[i], fst[i]});
                fq[i].push_back({fst[i], a[i], b[i]});
            end
        end
        for (int i = 0; i < NPE; i++) begin
            if (!reset && (dl[i] || ds[i])) begin
                model(i, e - 1, acc_m, ovf_m);
                if (dl[i]) begin
                    model(i, e - 2, acc_m, unused_ovf);
                    m     = (64'sd1 <<< wd[i]) - 1;
                    nd[i] = 32'(acc_m & m);
                end else begin
                    nd[i] = (i == 1) ? dmodel[0] : 32'd0;
                end
                dq[i].push_back({ovf_m, nd[i]});
            end
        end
        for (int i = 0; i < NPE; i++) begin
            if (reset) begin
                hist[i].delete();
                dmodel[i] = 32'd0;
            end else begin
                dmodel[i] = nd[i];
            end
        end
        @(posedge clk);
        #1;
        ec = e;
    endtask

    task automatic idle();
        for (int i = 0; i < NPE; i++) begin
            vld[i] = 1'b0;
            fst[i] = 1'b0;
            dl[i]  = 1'b0;
            ds[i]  = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NPE; i++) begin
            dev[i]  <= (dl[i] | ds[i]) & ~reset;
            bexp[i] <= vld[i] & ~reset;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NPE; i++) begin
                logic [16:0] f;
                logic [32:0] d;
                check($sformatf("busy%0d", i), 32'(busy[i]), 32'(bexp[i]));
                if (ov[i] === 1'b1) begin
                    if (fq[i].size() == 0) begin
                        check($sformatf("fwd_unexpected%0d", i), 32'(ov[i]), 32'd0);
                    end else begin
                        f = fq[i].pop_front();
                        check($sformatf("fwd%0d", i), 32'({of[i], oa[i], ob[i]}), 32'(f));
                    end
                end
                if (dev[i] && dq[i].size() != 0) begin
                    d = dq[i].pop_front();
                    check($sformatf("drain%0d", i), dout[i], d[31:0]);
                    check($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(d[32]));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NPE; i++) begin
            a[i]      = 8'd0;
            b[i]      = 8'd0;
            dmodel[i] = 32'd0;
        end
        idle();
        cyc();
        cyc();
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < NPE; i++) begin
            check("rst_dout", dout[i], 32'd0);
            check("rst_ovf", 32'(ovf[i]), 32'd0);
        end

        // Signed accumulate: 4 x (-3 * 5)
        vld[0] = 1'b1; fst[0] = 1'b1; a[0] = 8'hFD; b[0] = 8'd5;
        cyc();
        check("fwd_a_sgn", 32'(oa[0]), 32'h0000_00FD);
        check("fwd_b_sgn", 32'(ob[0]), 32'd5);
        fst[0] = 1'b0;
        repeat (3) cyc();
        vld[0] = 1'b0;
        cyc();
        dl[0] = 1'b1;
        cyc();
        dl[0] = 1'b0;
        check("sgn_acc", dout[0], 32'hFFFF_FFC4);
        check("sgn_ovf", 32'(ovf[0]), 32'd0);

        // Unsigned 16-bit: 255*255 twice, saturating vs wrapping
        for (int i = 2; i < 4; i++) begin
            vld[i] = 1'b1; fst[i] = 1'b1; a[i] = 8'hFF; b[i] = 8'hFF;
        end
        cyc();
        fst[2] = 1'b0; fst[3] = 1'b0;
        cyc();
        vld[2] = 1'b0; vld[3] = 1'b0; dl[2] = 1'b1; dl[3] = 1'b1;
        cyc();
        check("us_one_sat", dout[2], 32'd65025);
        check("us_one_wrap", dout[3], 32'd65025);
        cyc();
        check("us_sat", dout[2], 32'd65535);
        check("us_wrap", dout[3], 32'd64514);
        check("us_sat_ovf", 32'(ovf[2]), 32'd1);
        check("us_wrap_ovf", 32'(ovf[3]), 32'd1);
        idle();
        vld[2] = 1'b1; fst[2] = 1'b1; a[2] = 8'd1; b[2] = 8'd1;
        cyc();
        idle();
        cyc();
        dl[2] = 1'b1;
        cyc();
        dl[2] = 1'b0;
        check("us_restart", dout[2], 32'd1);
        check("us_restart_ovf", 32'(ovf[2]), 32'd0);

        // Bubbles on PE0, back-to-back restart on PE1, then the drain chain
        vld[0] = 1'b1; fst[0] = 1'b1; a[0] = 8'd2; b[0] = 8'd3;
        vld[1] = 1'b1; fst[1] = 1'b1; a[1] = 8'd5; b[1] = 8'd5;
        cyc();
        vld[0] = 1'b0; a[1] = 8'd1; b[1] = 8'd7;
        cyc();
        vld[1] = 1'b0;
        cyc();
        vld[0] = 1'b1; fst[0] = 1'b0; a[0] = 8'd4; b[0] = 8'd4;
        cyc();
        vld[0] = 1'b0;
        cyc();
        dl[0] = 1'b1; dl[1] = 1'b1;
        cyc();
        check("bubble_acc", dout[0], 32'd22);
        check("b2b_acc", dout[1], 32'd7);
        dl[0] = 1'b0; dl[1] = 1'b0; ds[0] = 1'b1; ds[1] = 1'b1;
        cyc();
        check("shift_dn", dout[1], 32'd22);
        check("shift_up", dout[0], 32'd0);
        dl[0] = 1'b1; dl[1] = 1'b1;
        cyc();
        check("load_wins_up", dout[0], 32'd22);
        check("load_wins_dn", dout[1], 32'd7);
        idle();

        // Reset with products in flight
        for (int i = 0; i < NPE; i++) begin
            vld[i] = 1'b1; fst[i] = 1'b1; a[i] = 8'hFF; b[i] = 8'hFF;
        end
        cyc();
        for (int i = 0; i < NPE; i++) fst[i] = 1'b0;
        cyc();
        cyc();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < NPE; i++) begin
            check($sformatf("mid_rst_busy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("mid_rst_ovf%0d", i), 32'(ovf[i]), 32'd0);
            check($sformatf("mid_rst_dout%0d", i), dout[i], 32'd0);
            check($sformatf("mid_rst_oval%0d", i), 32'(ov[i]), 32'd0);
        end
        cyc();
        for (int i = 0; i < NPE; i++) dl[i] = 1'b1;
        cyc();
        idle();
        for (int i = 0; i < NPE; i++) check($sformatf("no_late_acc%0d", i), dout[i], 32'd0);

        // Random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < NPE; i++) begin
                vld[i] = ($urandom_range(0, 3) != 0);
                fst[i] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 1) == 1) begin
                    a[i] = 8'($urandom);
                    b[i] = 8'($urandom);
                end else begin
                    a[i] = 8'($urandom_range(0, 7));
                    b[i] = 8'($urandom_range(0, 7));
                end
                dl[i] = ($urandom_range(0, 7) == 0);
                ds[i] = ($urandom_range(0, 5) == 0);
            end
            cyc();
        end
        reset = 1'b0;
        idle();
        cyc();
        cyc();
        @(negedge clk);
        #1;
        for (int i = 0; i < NPE; i++) begin
            check($sformatf("fwd_left%0d", i), 32'(fq[i].size()), 32'd0);
            check($sformatf("drain_left%0d", i), 32'(dq[i].size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
